cam_config_seq: RTL and testbench
=================================

Name: cam_config_seq

Overview:
Sequences the power-up register configuration of the OV7670 camera, which must complete before frame capture may begin. Walks a register table, issues one write per entry to an SCCB master via a request/done handshake, and retries entries that are NACKed. Honors in-table delay markers and raises config_done, which gates capture. The SCCB bit-level master is an external block; this module only schedules it.

Parameters:
PWRUP_CYC, 25000, clk cycles to wait after reset release or restart before the first write (1 ms @ 25 MHz)
DELAY_CYC, 25000, clk cycles waited at each delay-marker entry
GAP_CYC, 16, idle clk cycles between consecutive SCCB writes
MAX_RETRY, 3, extra attempts per entry after a NACK before declaring an error
TBL_DEPTH, 128, maximum table entries; index width = $clog2(TBL_DEPTH)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
restart  in  1  one-cycle pulse; re-runs the whole sequence from entry 0
sccb_req  out  1  write request to the SCCB master; held until accepted
sccb_ready  in  1  SCCB master idle; a request is accepted on a cycle where sccb_req && sccb_ready
sccb_addr  out  8  register address for the current write
sccb_data  out  8  register value for the current write
sccb_done  in  1  one-cycle pulse; the write finished
sccb_nack  in  1  valid with sccb_done; 1 means the slave NACKed
config_done  out  1  level; high once all entries have been written successfully
config_err  out  1  level; high when an entry exhausted its retries
err_index  out  $clog2(TBL_DEPTH)  table index that failed; valid while config_err is high
busy  out  1  high in every state except S_DONE and S_ERROR

Behaviour:
- Reset values: sccb_req=0, sccb_addr=0, sccb_data=0, config_done=0, config_err=0, err_index=0, busy=1. After reset, the state is S_PWRUP, index=0, retry=0, and the timer is loaded with PWRUP_CYC.
- Table entries are {addr[7:0], data[7:0]}.
  - 16'hFFFF is the end marker.
  - 16'hFFF0 is the delay marker.
  - Any other value is a register write.
- S_PWRUP: counts down PWRUP_CYC cycles, then moves to S_FETCH.
- S_FETCH: reads the entry at index. The table read is combinational, so the decision is made in the same cycle.
  - End marker -> S_DONE.
  - Delay marker -> S_DELAY.
  - Register write -> latch addr and data, then S_ISSUE.
- S_ISSUE: drives sccb_req=1 with stable addr and data. On the accept cycle, sccb_req drops on the next edge and the state moves to S_WAIT.
- S_WAIT: waits for sccb_done.
  - done && !nack -> index+1, retry=0, S_GAP.
  - done && nack && retry<MAX_RETRY -> retry+1, S_GAP; the same index is re-issued.
  - done && nack && retry==MAX_RETRY -> S_ERROR with err_index=index.
- S_GAP: waits GAP_CYC cycles, then S_FETCH.
- S_DELAY: waits DELAY_CYC cycles, then index+1 and S_FETCH. No SCCB traffic occurs.
- S_DONE: config_done=1 and busy=0. The state holds until restart.
- S_ERROR: config_err=1 and busy=0. The state holds until restart.
- Index wrap: if index reaches TBL_DEPTH-1 without hitting an end marker, that final entry is processed and then the sequence goes to S_DONE. The index never wraps to 0.
- Restart handling:
  - restart in any state synchronously clears config_done, config_err, retry and index, sets busy=1, and enters S_PWRUP.
  - If restart arrives in S_WAIT, the SCCB transfer in flight is abandoned. The sequencer still waits in S_PWRUP, so any late sccb_done is ignored.
  - restart has priority over sccb_done in the same cycle.
- sccb_done outside S_WAIT is ignored.
- Asserting reset_n low mid-transfer forces the reset values immediately; sccb_req drops asynchronously.
- A single down-counter of width $clog2(max(PWRUP_CYC, DELAY_CYC)+1) is shared by S_PWRUP, S_DELAY and S_GAP. It is loaded on state entry, and the state exits when the count reaches 0.
- Latency from accept to the next request with no NACK = sccb_done latency + 1 + GAP_CYC + 1 (FETCH) cycles.

Decomposition:
- Package cam_pkg holds:
  - state enum state_t
  - constants TBL_END=16'hFFFF and TBL_DELAY=16'hFFF0
  - struct reg_entry_t {addr, data}
- Sub-module cam_reg_rom: a combinational case-based table (input index, output reg_entry_t) holding the OV7670 RGB565/VGA register list.
  - Its first entry is 12h=80h (soft reset), followed by a delay marker.
  - It is kept separate so the test bench can substitute a small table.

Test Plan:
- Table {12:80, DELAY, 11:01, END}; PWRUP_CYC=10, DELAY_CYC=20, GAP_CYC=2; SCCB model gives ready=1 and done 5 cycles after accept, no NACK -> exactly 2 accepts (12/80, then 11/01); the 11/01 accept is at least 20 cycles after done#1; then config_done=1, busy=0, config_err=0.
- Same table, NACK on the first two attempts of 11:01 with MAX_RETRY=3 -> 11/01 is issued 3 times and config_done=1.
- NACK on every attempt of 11:01, MAX_RETRY=3 -> 4 issues of 11/01, then config_err=1, err_index=2, config_done=0, and no further sccb_req.
- sccb_ready held low 50 cycles during S_ISSUE -> sccb_req stays 1 with addr and data stable for all 50 cycles; exactly one accept occurs.
- restart pulsed in the same cycle as sccb_done in S_WAIT -> the done is ignored, config_done stays 0, and after PWRUP_CYC the first issue is 12/80 again; restart pulsed in S_DONE -> config_done falls next cycle and the sequence re-runs.
- reset_n asserted low while sccb_req=1 -> sccb_req=0 with no clock edge; after release, the PWRUP_CYC wait is observed before the first request.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and table markers for the OV7670 configuration sequencer.
package cam_pkg;

   typedef enum logic [2:0] {
      S_PWRUP,
      S_FETCH,
      S_ISSUE,
      S_WAIT,
      S_GAP,
      S_DELAY,
      S_DONE,
      S_ERROR
   } state_t;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } reg_entry_t;

   localparam logic [15:0] TBL_END   = 16'hFFFF;
   localparam logic [15:0] TBL_DELAY = 16'hFFF0;

endpackage

// File: rtl/cam_reg_rom.sv
// Combinational OV7670 register table (RGB565, VGA). SHORT_TBL selects a
// four-entry bring-up table used for fast simulation of the sequencer.
module cam_reg_rom
   import cam_pkg::*;
#(
   parameter int IW        = 7,
   parameter bit SHORT_TBL = 1'b0
) (
   input  logic [IW-1:0] i_index,
   output reg_entry_t    o_entry
);

   // Table lookup; anything past the last listed entry reads as the end marker.
   always_comb begin
      o_entry = TBL_END;
      if (SHORT_TBL) begin
         case (int'(i_index))
            0:       o_entry = 16'h1280;
            1:       o_entry = TBL_DELAY;
            2:       o_entry = 16'h1101;
            default: o_entry = TBL_END;
         endcase
      end else begin
         case (int'(i_index))
            0:       o_entry = 16'h1280;   // COM7: soft reset
            1:       o_entry = TBL_DELAY;  // let the sensor come out of reset
            2:       o_entry = 16'h1204;   // COM7: RGB output, VGA
            3:       o_entry = 16'h1101;   // CLKRC: prescaler
            4:       o_entry = 16'h0C00;   // COM3
            5:       o_entry = 16'h3E00;   // COM14: no scaling
            6:       o_entry = 16'h40D0;   // COM15: RGB565, full range
            7:       o_entry = 16'h8C00;   // RGB444 off
            8:       o_entry = 16'h0400;   // COM1
            9:       o_entry = 16'h3A04;   // TSLB
            10:      o_entry = 16'h1438;   // COM9: AGC ceiling
            11:      o_entry = 16'h4FB3;   // colour matrix
            12:      o_entry = 16'h50B3;
            13:      o_entry = 16'h5100;
            14:      o_entry = 16'h523D;
            15:      o_entry = 16'h53A7;
            16:      o_entry = 16'h54E4;
            17:      o_entry = 16'h589E;   // MTXS
            18:      o_entry = 16'h3DC0;   // COM13: gamma, UV saturation
            19:      o_entry = 16'h1713;   // HSTART
            20:      o_entry = 16'h1801;   // HSTOP
            21:      o_entry = 16'h32B6;   // HREF
            22:      o_entry = 16'h1902;   // VSTART
            23:      o_entry = 16'h1A7A;   // VSTOP
            24:      o_entry = 16'h030A;   // VREF
            25:      o_entry = 16'h0F41;   // COM6
            26:      o_entry = 16'h1E00;   // MVFP
            27:      o_entry = 16'h330B;   // CHLF
            28:      o_entry = 16'h3C78;   // COM12
            29:      o_entry = 16'h6900;   // GFIX
            30:      o_entry = 16'h7400;   // REG74
            31:      o_entry = 16'hB084;   // RSVD, needed for good colour
            32:      o_entry = 16'hB10C;   // ABLC1
            33:      o_entry = 16'hB20E;
            34:      o_entry = 16'hB380;   // THL_ST
            default: o_entry = TBL_END;
         endcase
      end
   end

endmodule

// File: rtl/cam_config_seq.sv
// Power-up configuration sequencer for the OV7670: walks the register table,
// schedules one SCCB write per entry, retries NACKs and raises config_done.
module cam_config_seq
   import cam_pkg::*;
#(
   parameter int PWRUP_CYC = 25000,
   parameter int DELAY_CYC = 25000,
   parameter int GAP_CYC   = 16,
   parameter int MAX_RETRY = 3,
   parameter int TBL_DEPTH = 128,
   parameter bit SHORT_TBL = 1'b0
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         restart,
   output logic                         sccb_req,
   input  logic                         sccb_ready,
   output logic [7:0]                   sccb_addr,
   output logic [7:0]                   sccb_data,
   input  logic                         sccb_done,
   input  logic                         sccb_nack,
   output logic                         config_done,
   output logic                         config_err,
   output logic [$clog2(TBL_DEPTH)-1:0] err_index,
   output logic                         busy
);

   localparam int IW   = $clog2(TBL_DEPTH);
   localparam int TMAX = (PWRUP_CYC > DELAY_CYC) ? PWRUP_CYC : DELAY_CYC;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int RW   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [IW-1:0] LAST = IW'(TBL_DEPTH - 1);

   state_t        r_state, w_state_nxt;
   logic [TW-1:0] r_timer, w_timer_nxt;
   logic [IW-1:0] r_index, w_index_nxt;
   logic [RW-1:0] r_retry, w_retry_nxt;
   logic [7:0]    r_addr,  w_addr_nxt;
   logic [7:0]    r_data,  w_data_nxt;
   logic [IW-1:0] r_err,   w_err_nxt;
   reg_entry_t    w_entry;

   cam_reg_rom #(
      .IW        (IW),
      .SHORT_TBL (SHORT_TBL)
   ) u_rom (
      .i_index (r_index),
      .o_entry (w_entry)
   );

   // State register and datapath; reset parks in S_PWRUP with the power-up wait loaded.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_PWRUP;
         r_timer <= TW'(PWRUP_CYC);
         r_index <= '0;
         r_retry <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_err   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
         r_index <= w_index_nxt;
         r_retry <= w_retry_nxt;
         r_addr  <= w_addr_nxt;
         r_data  <= w_data_nxt;
         r_err   <= w_err_nxt;
      end
   end

   // Next-state logic. Timed states leave on the cycle the shared counter would
   // reach zero, so a load of N gives exactly N cycles in the state.
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_index_nxt = r_index;
      w_retry_nxt = r_retry;
      w_addr_nxt  = r_addr;
      w_data_nxt  = r_data;
      w_err_nxt   = r_err;
      if (restart) begin
         // Restart wins over everything, including a done landing this cycle.
         w_state_nxt = S_PWRUP;
         w_timer_nxt = TW'(PWRUP_CYC);
         w_index_nxt = '0;
         w_retry_nxt = '0;
         w_err_nxt   = '0;
      end else begin
         case (r_state)
            S_PWRUP, S_GAP: begin
               if (r_timer <= TW'(1)) w_state_nxt = S_FETCH;
               else                   w_timer_nxt = r_timer - TW'(1);
            end
            S_FETCH: begin
               if (w_entry == TBL_END) begin
                  w_state_nxt = S_DONE;
               end else if (w_entry == TBL_DELAY) begin
                  w_state_nxt = S_DELAY;
                  w_timer_nxt = TW'(DELAY_CYC);
               end else begin
                  w_addr_nxt  = w_entry.addr;
                  w_data_nxt  = w_entry.data;
                  w_state_nxt = S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (sccb_ready) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
               if (sccb_done) begin
                  if (!sccb_nack) begin
                     w_retry_nxt = '0;
                     // The last table slot finishes the run instead of wrapping.
                     if (r_index == LAST) begin
                        w_state_nxt = S_DONE;
                     end else begin
                        w_index_nxt = r_index + IW'(1);
                        w_state_nxt = S_GAP;
                        w_timer_nxt = TW'(GAP_CYC);
                     end
                  end else if (r_retry < RW'(MAX_RETRY)) begin
                     w_retry_nxt = r_retry + RW'(1);
                     w_state_nxt = S_GAP;
                     w_timer_nxt = TW'(GAP_CYC);
                  end else begin
                     w_err_nxt   = r_index;
                     w_state_nxt = S_ERROR;
                  end
               end
            end
            S_DELAY: begin
               if (r_timer <= TW'(1)) begin
                  if (r_index == LAST) begin
                     w_state_nxt = S_DONE;
                  end else begin
                     w_index_nxt = r_index + IW'(1);
                     w_state_nxt = S_FETCH;
                  end
               end else begin
                  w_timer_nxt = r_timer - TW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs decode straight from state so reset drops sccb_req without a clock.
   assign sccb_req    = (r_state == S_ISSUE);
   assign sccb_addr   = r_addr;
   assign sccb_data   = r_data;
   assign config_done = (r_state == S_DONE);
   assign config_err  = (r_state == S_ERROR);
   assign busy        = (r_state != S_DONE) && (r_state != S_ERROR);
   assign err_index   = r_err;

endmodule

// File: tb/tb_cam_config_seq.sv
// Scoreboard bench for cam_config_seq on the short table {12:80, DELAY, 11:01, END}.
// The main process queues expected writes and level checks; the SCCB model /
// monitor process drives the slave side, pops the queues and does all comparing.
module tb_cam_config_seq;

   localparam int PWR  = 10;
   localparam int DLY  = 20;
   localparam int GAP  = 2;
   localparam int DONE_LAT = 5;
   localparam int HOLD = 50;

   localparam int SIG_REQ = 0, SIG_ADDR = 1, SIG_DATA = 2, SIG_DONE = 3, SIG_ERR = 4,
                  SIG_EIDX = 5, SIG_BUSY = 6, SIG_PEND = 7, SIG_GAPM = 8;

   typedef struct {
      int          sig;
      logic [31:0] exp;
   } chk_t;

   logic       clk, reset_n, restart;
   logic       sccb_req, sccb_ready, sccb_done, sccb_nack;
   logic [7:0] sccb_addr, sccb_data;
   logic       config_done, config_err, busy;
   logic [6:0] err_index;

   cam_config_seq #(
      .PWRUP_CYC (PWR),
      .DELAY_CYC (DLY),
      .GAP_CYC   (GAP),
      .MAX_RETRY (3),
      .TBL_DEPTH (128),
      .SHORT_TBL (1'b1)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .restart     (restart),
      .sccb_req    (sccb_req),
      .sccb_ready  (sccb_ready),
      .sccb_addr   (sccb_addr),
      .sccb_data   (sccb_data),
      .sccb_done   (sccb_done),
      .sccb_nack   (sccb_nack),
      .config_done (config_done),
      .config_err  (config_err),
      .err_index   (err_index),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard queues (main pushes, monitor pops)
   logic [15:0] exp_q[$];
   chk_t        lvl_q[$];

   // control requests from main, acknowledged by counters owned by the model
   int nack_mode = 0;   // 0 none, 1 NACK first two tries of reg 11, 2 NACK all of them
   int rs_req = 0, rod_arm = 0, hold_arm = 0;

   // model / monitor state
   int n_pass = 0, n_tot = 0;
   int rs_ack = 0, rod_ack = 0, hold_ack = 0;
   int cyc = 0, dcnt = 0, att11 = 0, last_done = 0, gap_meas = 0, hold_cnt = 0;
   logic hold_on = 1'b0, pend_nack = 1'b0;
   logic [15:0] got;
   chk_t        c;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   function automatic logic [31:0] sig_val(input int s);
      case (s)
         SIG_REQ:  return {31'd0, sccb_req};
         SIG_ADDR: return {24'd0, sccb_addr};
         SIG_DATA: return {24'd0, sccb_data};
         SIG_DONE: return {31'd0, config_done};
         SIG_ERR:  return {31'd0, config_err};
         SIG_EIDX: return {25'd0, err_index};
         SIG_BUSY: return {31'd0, busy};
         SIG_PEND: return 32'(exp_q.size());
         default:  return 32'(gap_meas);
      endcase
   endfunction

   function automatic string sig_name(input int s);
      case (s)
         SIG_REQ:  return "sccb_req";
         SIG_ADDR: return "sccb_addr";
         SIG_DATA: return "sccb_data";
         SIG_DONE: return "config_done";
         SIG_ERR:  return "config_err";
         SIG_EIDX: return "err_index";
         SIG_BUSY: return "busy";
         SIG_PEND: return "writes_outstanding";
         default:  return "done_to_accept_cycles";
      endcase
   endfunction

   // SCCB slave model and monitor; everything happens on the falling edge.
   initial begin
      sccb_ready = 1'b1;
      sccb_done  = 1'b0;
      sccb_nack  = 1'b0;
      restart    = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         sccb_done = 1'b0;
         sccb_nack = 1'b0;
         restart   = 1'b0;
         if (!reset_n) dcnt = 0;
         if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) begin
               sccb_done = 1'b1;
               sccb_nack = pend_nack;
               last_done = cyc;
               if (rod_ack < rod_arm) begin
                  restart = 1'b1;
                  rod_ack++;
                  att11 = 0;
               end
            end
         end
         if (rs_ack < rs_req) begin
            restart = 1'b1;
            rs_ack++;
            att11 = 0;
            dcnt  = 0;
         end
         sccb_ready = 1'b1;
         if (hold_ack < hold_arm) begin
            if (sccb_req) hold_on = 1'b1;
            if (hold_on && reset_n) begin
               hold_cnt++;
               check("hold_req", {31'd0, sccb_req}, 32'd1);
               if (exp_q.size() > 0)
                  check("hold_addr_data", {16'd0, sccb_addr, sccb_data}, {16'd0, exp_q[0]});
            end
            if (hold_cnt > HOLD) begin
               hold_ack++;
               hold_on  = 1'b0;
               hold_cnt = 0;
            end else begin
               sccb_ready = 1'b0;
            end
         end
         if (reset_n && sccb_req && sccb_ready) begin
            got      = {sccb_addr, sccb_data};
            gap_meas = cyc - last_done;
            if (exp_q.size() == 0) begin
               n_tot++;
               $display("FAIL accept: got unexpected write %h expected none (cycle %0d)", got, cyc);
            end else begin
               check("accept", {16'd0, got}, {16'd0, exp_q.pop_front()});
            end
            pend_nack = (sccb_addr == 8'h11) &&
                        ((nack_mode == 2) || ((nack_mode == 1) && (att11 < 2)));
            if (sccb_addr == 8'h11) att11++;
            dcnt = DONE_LAT;
         end
         while (lvl_q.size() > 0) begin
            c = lvl_q.pop_front();
            check(sig_name(c.sig), sig_val(c.sig), c.exp);
         end
      end
   end

   task automatic expect_lvl(input int s, input logic [31:0] v);
      lvl_q.push_back('{sig: s, exp: v});
   endtask

   task automatic wait_end(input int lim);
      for (int i = 0; i < lim; i++) begin
         @(posedge clk);
         if (config_done || config_err) break;
      end
      @(posedge clk);
   endtask

   task automatic wait_restart();
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         if (restart) break;
      end
   endtask

   initial begin
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      // reset values
      expect_lvl(SIG_REQ, 0);  expect_lvl(SIG_ADDR, 0); expect_lvl(SIG_DATA, 0);
      expect_lvl(SIG_DONE, 0); expect_lvl(SIG_ERR, 0);  expect_lvl(SIG_EIDX, 0);
      expect_lvl(SIG_BUSY, 1);

      // 1: clean run; power-up wait, then 12/80, delay, 11/01
      @(posedge clk);
      exp_q.push_back(16'h1280);
      exp_q.push_back(16'h1101);
      #1 reset_n = 1'b1;
      repeat (PWR) @(posedge clk);
      expect_lvl(SIG_REQ, 0);
      wait_end(400);
      expect_lvl(SIG_DONE, 1); expect_lvl(SIG_ERR, 0); expect_lvl(SIG_BUSY, 0);
      expect_lvl(SIG_PEND, 0);
      // done -> GAP(2) -> FETCH -> DELAY(20) -> FETCH -> ISSUE
      expect_lvl(SIG_GAPM, 25);

      // 2: restart from S_DONE, two NACKs on 11/01 then success
      @(posedge clk);
      nack_mode = 1;
      exp_q.push_back(16'h1280);
      repeat (3) exp_q.push_back(16'h1101);
      rs_req++;
      wait_restart();
      expect_lvl(SIG_DONE, 0); expect_lvl(SIG_BUSY, 1);
      wait_end(400);
      expect_lvl(SIG_DONE, 1); expect_lvl(SIG_ERR, 0); expect_lvl(SIG_PEND, 0);
      // retry path: done -> GAP(2) -> FETCH -> ISSUE
      expect_lvl(SIG_GAPM, 4);

      // 3: every try of 11/01 NACKed -> 4 issues then error at index 2
      @(posedge clk);
      nack_mode = 2;
      exp_q.push_back(16'h1280);
      repeat (4) exp_q.push_back(16'h1101);
      rs_req++;
      wait_restart();
      wait_end(400);
      expect_lvl(SIG_ERR, 1);  expect_lvl(SIG_EIDX, 2);
      expect_lvl(SIG_DONE, 0); expect_lvl(SIG_BUSY, 0);
      repeat (30) @(posedge clk);
      expect_lvl(SIG_REQ, 0);  expect_lvl(SIG_PEND, 0);

      // 4: slave not ready for 50 cycles on the first request
      @(posedge clk);
      nack_mode = 0;
      hold_arm++;
      exp_q.push_back(16'h1280);
      exp_q.push_back(16'h1101);
      rs_req++;
      wait_restart();
      wait_end(600);
      expect_lvl(SIG_DONE, 1); expect_lvl(SIG_PEND, 0);

      // 5: restart coincides with the first done -> that done is dropped
      @(posedge clk);
      rod_arm++;
      exp_q.push_back(16'h1280);
      exp_q.push_back(16'h1280);
      exp_q.push_back(16'h1101);
      rs_req++;
      wait_restart();
      wait_restart();
      expect_lvl(SIG_DONE, 0); expect_lvl(SIG_BUSY, 1);
      wait_end(400);
      expect_lvl(SIG_DONE, 1); expect_lvl(SIG_ERR, 0); expect_lvl(SIG_PEND, 0);

      // 6: reset_n pulled while sccb_req is high
      @(posedge clk);
      rs_req++;
      wait_restart();
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (sccb_req) begin
            reset_n = 1'b0;
            break;
         end
      end
      expect_lvl(SIG_REQ, 0);  expect_lvl(SIG_ADDR, 0); expect_lvl(SIG_DATA, 0);
      expect_lvl(SIG_BUSY, 1); expect_lvl(SIG_DONE, 0);
      repeat (3) @(posedge clk);
      exp_q.push_back(16'h1280);
      exp_q.push_back(16'h1101);
      #1 reset_n = 1'b1;
      repeat (PWR) @(posedge clk);
      expect_lvl(SIG_REQ, 0);
      wait_end(400);
      expect_lvl(SIG_DONE, 1); expect_lvl(SIG_PEND, 0);

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
